// File: rtl/load_store_unit.sv
// Load/store unit: sequences one aligned memory access at a time through IDLE/ISSUE/WAIT/DONE.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into a no-access error completion.
module load_store_unit #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] ld_data_o,
  output logic        addr_err_o,
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wr_data_o,
  input  logic [31:0] mem_rd_data_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  wait_cnt, wait_cnt_nxt;
  logic        we_p0;
  logic        trap_p0;
  logic [2:0]  op_p0;
  logic [1:0]  off_p0;
  logic        accept;
  logic        trap_acc;
  logic        rd_last;

  // Size encoding shared by loads and stores: op[1:0] 00 byte, 01 half, 1x word.
  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    if (sz[1])
      be = 4'b1111;
    else if (sz[0])
      be = off[1] ? 4'b0011 : 4'b1100;
    else
      be = 4'b1000 >> off;
    return be;
  endfunction

  function automatic logic [31:0] store_rep(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    if (sz[1])
      r = d;
    else if (sz[0])
      r = {2{d[15:0]}};
    else
      r = {4{d[7:0]}};
    return r;
  endfunction

  // Big-endian lane pick: offset 0 is bits 31:24.
  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    if (op[1])
      r = w;
    else if (op[0])
      r = op[2] ? {16'h0000, h} : {{16{h[15]}}, h};
    else
      r = op[2] ? {24'h000000, b} : {{24{b[7]}}, b};
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic m;
    if (sz[1])
      m = (off != 2'b00);
    else if (sz[0])
      m = off[0];
    else
      m = 1'b0;
    return m;
  endfunction

`ifdef MISALIGN_TRAP_EN
  assign trap_acc = misaligned(op_i[1:0], addr_i[1:0]);
`else
  assign trap_acc = 1'b0;
`endif

  assign accept  = (state == IDLE) && req_i;
  assign rd_last = (state == WAIT) && (wait_cnt == 2'd0);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (req_i) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (we_p0 || trap_p0) begin
          state_nxt = DONE;
        end else begin
          state_nxt    = WAIT;
          wait_cnt_nxt = 2'(RD_LATENCY - 1);
        end
      end
      WAIT: begin
        if (wait_cnt == 2'd0)
          state_nxt = DONE;
        else
          wait_cnt_nxt = wait_cnt - 2'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: FSM state and every output are registered from next-state decisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= 2'd0;
      we_p0         <= 1'b0;
      trap_p0       <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      addr_err_o    <= 1'b0;
      mem_rd_en_o   <= 1'b0;
      mem_wr_en_o   <= 1'b0;
      mem_be_o      <= 4'b0000;
      mem_addr_o    <= 32'h0;
      mem_wr_data_o <= 32'h0;
      ld_data_o     <= 32'h0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      busy_o      <= (state_nxt != IDLE);
      done_o      <= (state_nxt == DONE);
      addr_err_o  <= (state_nxt == DONE) && (state == ISSUE) && trap_p0;
      mem_rd_en_o <= accept && !we_i && !trap_acc;
      mem_wr_en_o <= accept && we_i && !trap_acc;
      mem_be_o    <= (accept && we_i && !trap_acc) ? store_be(op_i[1:0], addr_i[1:0]) : 4'b0000;
      if (accept) begin
        we_p0      <= we_i;
        trap_p0    <= trap_acc;
        mem_addr_o <= {addr_i[31:2], 2'b00};
        if (we_i)
          mem_wr_data_o <= store_rep(op_i[1:0], st_data_i);
      end
      if (rd_last)
        ld_data_o <= load_ext(op_p0, off_p0, mem_rd_data_i);
    end
  end

  // Access attributes are pure data: captured on accept, never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0  <= op_i;
      off_p0 <= addr_i[1:0];
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (RD_LATENCY=2) with a latency-accurate read model.
module tb_load_store_unit;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [2:0]  op  = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] st = 32'h0;
  logic [31:0] rd_data;
  logic        busy, done, addr_err, rd_en, wr_en;
  logic [3:0]  be;
  logic [31:0] ld_data, mem_addr, wr_data;
  logic [31:0] mem_word = 32'h80F07F01;
  logic [3:0]  sr = 4'b0000;
  int          checks = 0;
  int          failures = 0;
  int          n_done, n_wr;

  load_store_unit #(.RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .op_i(op), .addr_i(addr),
    .st_data_i(st), .busy_o(busy), .done_o(done), .ld_data_o(ld_data),
    .addr_err_o(addr_err), .mem_rd_en_o(rd_en), .mem_wr_en_o(wr_en),
    .mem_be_o(be), .mem_addr_o(mem_addr), .mem_wr_data_o(wr_data),
    .mem_rd_data_i(rd_data)
  );

  always #5 clk = ~clk;

  // Memory answers exactly LAT cycles after the read strobe, garbage otherwise.
  always @(posedge clk) sr <= {sr[2:0], rd_en};
  assign rd_data = sr[LAT-1] ? mem_word : 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic w, input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; op = o; addr = a; st = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] xbe, input logic [31:0] xdata);
    start(1'b1, o, a, d);
    chk({tag, ".wr_en"}, wr_en, 1);
    chk({tag, ".rd_en"}, rd_en, 0);
    chk({tag, ".be"}, be, xbe);
    chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, ".wdata"}, wr_data, xdata);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".done_early"}, done, 0);
    @(negedge clk);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".wr_en_off"}, wr_en, 0);
    chk({tag, ".be_off"}, be, 0);
    @(negedge clk);
    chk({tag, ".idle"}, busy, 0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] xld);
    start(1'b0, o, a, 32'h0);
    chk({tag, ".rd_en"}, rd_en, 1);
    chk({tag, ".wr_en"}, wr_en, 0);
    chk({tag, ".be"}, be, 0);
    chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
    @(negedge clk);
    chk({tag, ".rd_en_off"}, rd_en, 0);
    chk({tag, ".busy_wait"}, busy, 1);
    chk({tag, ".done_w1"}, done, 0);
    @(negedge clk);
    chk({tag, ".done_w2"}, done, 0);
    @(negedge clk);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".ld_data"}, ld_data, xld);
    chk({tag, ".addr_err"}, addr_err, 0);
    @(negedge clk);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.strobes", {rd_en, wr_en}, 0);
    chk("rst.be", be, 0);
    chk("rst.ld_data", ld_data, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.wdata", wr_data, 0);
    chk("rst.addr_err", addr_err, 0);
    rst = 1'b0;

    do_store("sw", 3'b011, 32'h10, 32'h11223344, 4'b1111, 32'h11223344);
    do_store("sb3", 3'b000, 32'h13, 32'h000000AB, 4'b0001, 32'hABABABAB);
    do_store("sb0u", 3'b100, 32'h10, 32'h000000CD, 4'b1000, 32'hCDCDCDCD);
    do_store("sh2", 3'b001, 32'h12, 32'h0000BEEF, 4'b0011, 32'hBEEFBEEF);
    do_store("sh0", 3'b101, 32'h10, 32'h00001234, 4'b1100, 32'h12341234);

    do_load("lb0", 3'b000, 32'h20, 32'hFFFFFF80);
    do_load("lbu0", 3'b100, 32'h20, 32'h00000080);
    do_load("lh2", 3'b001, 32'h22, 32'h00007F01);
    do_load("lhu0", 3'b101, 32'h20, 32'h000080F0);
    do_load("lh0", 3'b001, 32'h20, 32'hFFFF80F0);
    do_load("lb3", 3'b000, 32'h23, 32'h00000001);
    do_load("lb2", 3'b000, 32'h22, 32'h0000007F);
    do_load("lbu1", 3'b100, 32'h21, 32'h000000F0);
    do_load("lw", 3'b011, 32'h20, 32'h80F07F01);
    do_load("lw111", 3'b111, 32'h24, 32'h80F07F01);

    do_store("sw_hold", 3'b011, 32'h30, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    chk("ld_hold_store", ld_data, 32'h80F07F01);

    mem_word = 32'h12345678;
`ifdef MISALIGN_TRAP_EN
    start(1'b0, 3'b011, 32'h22, 32'h0);
    chk("trap.strobes", {rd_en, wr_en}, 0);
    chk("trap.be", be, 0);
    chk("trap.busy", busy, 1);
    chk("trap.done_early", done, 0);
    @(negedge clk);
    chk("trap.done", done, 1);
    chk("trap.addr_err", addr_err, 1);
    chk("trap.ld_hold", ld_data, 32'h80F07F01);
    chk("trap.no_strobe", rd_en, 0);
    @(negedge clk);
    chk("trap.idle", busy, 0);
    chk("trap.err_clr", addr_err, 0);
`else
    do_load("lw_misal", 3'b011, 32'h22, 32'h12345678);
`endif

    // Abort from WAIT: reset is asynchronous and suppresses completion.
    start(1'b0, 3'b011, 32'h20, 32'h0);
    @(negedge clk);
    chk("abort.in_wait", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.ld_data", ld_data, 0);
    chk("abort.addr", mem_addr, 0);
    chk("abort.wdata", wr_data, 0);
    chk("abort.strobes_be", {rd_en, wr_en, be}, 0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort.no_done", n_done, 0);

    // Abort from ISSUE: the strobe must fall without a clock edge.
    start(1'b0, 3'b011, 32'h20, 32'h0);
    chk("abort2.strobe_on", rd_en, 1);
    rst = 1'b1;
    #1;
    chk("abort2.strobe_off", rd_en, 0);
    @(negedge clk);
    rst = 1'b0;
    do_load("after_rst", 3'b100, 32'h21, 32'h00000034);

    // req held high: accepted only from IDLE, one completion each.
    req = 1'b1; we = 1'b1; op = 3'b011; addr = 32'h40; st = 32'h55555555;
    n_done = 0;
    n_wr = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (wr_en) n_wr++;
      if (i == 2) chk("b2b.idle_gap", busy, 0);
      if (i == 3) chk("b2b.reissue", wr_en, 1);
    end
    req = 1'b0;
    chk("b2b.dones", n_done, 4);
    chk("b2b.writes", n_wr, 4);
    @(negedge clk);
    chk("b2b.stop", busy, 0);
    chk("b2b.ld_hold", ld_data, 32'h00000034);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
